// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx                                                          |
// | Desc    : 8N1 UART receiver with one-byte valid/ready holding register.    |
// |           Define UART_RX_PARITY_EN for an even-parity bit before stop.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       parity_err
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int C_CNT_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [C_CNT_W-1:0] C_BIT_END  = C_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [C_CNT_W-1:0] C_HALF_END = C_CNT_W'(HALF_BIT - 1);

  localparam logic [2:0] C_ST_IDLE  = 3'd0;
  localparam logic [2:0] C_ST_START = 3'd1;
  localparam logic [2:0] C_ST_DATA  = 3'd2;
  localparam logic [2:0] C_ST_STOP  = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] C_ST_PARITY    = 3'd4;
  localparam logic [2:0] C_ST_AFTER_DAT = C_ST_PARITY;
`else
  localparam logic [2:0] C_ST_AFTER_DAT = C_ST_STOP;
`endif

  logic               rx_meta_q, rx_s_q, rx_d_q;
  logic [2:0]         state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               framing_err_q, framing_err_d;
  logic               overrun_q, overrun_d;
  logic               byte_ok;
`ifdef UART_RX_PARITY_EN
  logic               par_bad_q, par_bad_d;
  logic               parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    framing_err_d = 1'b0;
    byte_ok       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_err_d  = 1'b0;
`endif
    case (state_q)
      C_ST_IDLE: begin
        if (rx_d_q && !rx_s_q) begin
          state_d = C_ST_START;
          cnt_d   = '0;
        end
      end
      C_ST_START: begin
        if (cnt_q == C_HALF_END) begin
          // A start bit that has gone high again by mid-bit was a glitch.
          if (!rx_s_q) begin
            state_d   = C_ST_DATA;
            cnt_d     = '0;
            bit_cnt_d = '0;
          end else begin
            state_d = C_ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      C_ST_DATA: begin
        if (cnt_q == C_BIT_END) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = C_ST_AFTER_DAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      C_ST_PARITY: begin
        if (cnt_q == C_BIT_END) begin
          par_bad_d    = (^shift_q) ^ rx_s_q;
          parity_err_d = par_bad_d;
          cnt_d        = '0;
          state_d      = C_ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      C_ST_STOP: begin
        if (cnt_q == C_BIT_END) begin
          state_d       = C_ST_IDLE;
          framing_err_d = !rx_s_q;
`ifdef UART_RX_PARITY_EN
          byte_ok       = rx_s_q && !par_bad_q;
`else
          byte_ok       = rx_s_q;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = C_ST_IDLE;
    endcase
  end

  // A completing byte may refill the register in the same cycle it is consumed.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (byte_ok) begin
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_d_q        <= 1'b1;
      state_q       <= C_ST_IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      rx_d_q        <= rx_s_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_rx                                                       |
// | Desc    : Self-checking bench for uart_rx at 16 clocks per bit.            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_uart_rx;
  localparam int CLK_FREQ  = 16;
  localparam int BAUD_RATE = 1;
  localparam int BIT_CLKS  = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Edge at clock 0 is seen 3 clocks later (2 sync + edge flop), start sampled
  // 8 clocks after that, stop sampled 9 (+parity) bit periods later.
  localparam int C_LATENCY = 3 + 8 + BIT_CLKS * (9 + PAR_BITS);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, framing_err, overrun, parity_err;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .framing_err(framing_err), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, both_cnt = 0;
  int         valid_cyc = 0, rise_cyc = -1;
  logic       valid_prev = 1'b0;
  logic [7:0] got_q[$];

  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (valid && ready) got_q.push_back(data);
      if (framing_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (parity_err) pe_cnt++;
      if (framing_err && overrun) both_cnt++;
      if (valid) valid_cyc++;
      if (valid && !valid_prev) rise_cyc = cyc;
    end
    valid_prev = valid;
  end

  // Reference model: bytes expected to be consumed, expected pulse totals.
  logic [7:0] exp_q[$];
  int         exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic       m_full = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         errors = 0, checks = 0;
  int         t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic set_ready(input logic r);
    step();
    ready = r;
    if (r && m_full) begin
      exp_q.push_back(m_byte);
      m_full = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    step();
    t0 = cyc;
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    hold(BIT_CLKS);
`endif
    rx = stop_bit;
    hold(BIT_CLKS);
    if (PAR_BITS != 0 && par_flip) exp_pe++;
    if (!stop_bit) exp_fe++;
    if (stop_bit && !(PAR_BITS != 0 && par_flip)) begin
      if (m_full && !ready) exp_ov++;
      else if (ready) exp_q.push_back(b);
      else begin
        m_full = 1'b1;
        m_byte = b;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    hold(3);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, got_q[i], exp_q[i]);
    chk({tag, "_fe"}, fe_cnt, exp_fe);
    chk({tag, "_ov"}, ov_cnt, exp_ov);
    chk({tag, "_pe"}, pe_cnt, exp_pe);
    chk({tag, "_fe_and_ov"}, both_cnt, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int vc;
    logic [7:0] b;
    logic r, s, p;

    hold(4);
    rst_n = 1'b1;
    hold(2);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_fe", framing_err, 1'b0);
    chk("rst_ov", overrun, 1'b0);
    chk("rst_pe", parity_err, 1'b0);

    // Single byte, consumer always ready.
    set_ready(1'b1);
    vc = valid_cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("t1_latency", rise_cyc - t0, C_LATENCY);
    hold(3);
    chk("t1_valid_cycles", valid_cyc - vc, 1);
    chk("t1_valid_low", valid, 1'b0);
    check_model("t1");

    // Holding register full, second byte overruns.
    set_ready(1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("t2_valid_held", valid, 1'b1);
    chk("t2_data_held", data, 8'h3C);
    set_ready(1'b1);
    hold(2);
    chk("t2_valid_after", valid, 1'b0);
    check_model("t2");

    // Short low glitch is not a start bit.
    step();
    rx = 1'b0;
    hold(4);
    rx = 1'b1;
    hold(200);
    chk("t3_valid", valid, 1'b0);
    check_model("t3");
    send_frame(8'h6E, 1'b1, 1'b0);
    check_model("t3_recover");

    // Bad stop bit, then line stuck low must not re-arm.
    send_frame(8'h55, 1'b0, 1'b0);
    chk("t4_valid", valid, 1'b0);
    hold(40);
    chk("t4_stuck_valid", valid, 1'b0);
    check_model("t4");
    rx = 1'b1;
    hold(BIT_CLKS);
    send_frame(8'h99, 1'b1, 1'b0);
    check_model("t4_recover");

    // Reset in the middle of bit 3 of 8'hFF.
    step();
    rx = 1'b0;
    hold(BIT_CLKS);
    rx = 1'b1;
    hold(3 * BIT_CLKS + 5);
    rst_n = 1'b0;
    m_full = 1'b0;
    hold(3);
    rst_n = 1'b1;
    hold(BIT_CLKS * 6);
    send_frame(8'h12, 1'b1, 1'b0);
    check_model("t5");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    chk("t6_valid_bad", valid, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    check_model("t6");
`endif

    // Random frames with random ready and occasional line errors.
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 5) != 0);
      p = (PAR_BITS != 0) && ($urandom_range(0, 4) == 0);
      set_ready(r);
      send_frame(b, s, p);
      if (!s) begin
        rx = 1'b1;
        hold(BIT_CLKS);
      end
    end
    set_ready(1'b1);
    check_model("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
